uart_tx_bus: RTL and testbench

Memory-mapped UART transmitter that sits directly downstream of the CPU on its single memory bus (`dir`, `dat_escritura`, `hab_escritura`) and returns status on the shared `dat_lectura` path. Stores from the CPU push bytes into a transmit buffer. A bit-serial state machine shifts each byte out as an 8N1 frame on `tx`. Reads are combinational so a load can capture the value in the same cycle the address is presented.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx_bus_if.sv | 12 +
 rtl/fifo_sinc.sv | 52 +++++
 rtl/uart_tx_bus.sv | 182 ++++++++++++++++++
 tb/tb_uart_tx_bus.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions and the 2-bit transmit FSM state encoding.
package uart_pkg;

  localparam logic [1:0] OFS_DATA   = 2'd0;
  localparam logic [1:0] OFS_STATUS = 2'd1;
  localparam logic [1:0] OFS_DIV    = 2'd2;

  localparam int ST_OCUPADO   = 0;
  localparam int ST_LLENO     = 1;
  localparam int ST_VACIO     = 2;
  localparam int ST_DESBORDE  = 3;
  localparam int ST_COUNT_LSB = 4;

  typedef logic [1:0] estado_t;

  localparam estado_t EST_IDLE  = 2'd0;
  localparam estado_t EST_START = 2'd1;
  localparam estado_t EST_DATA  = 2'd2;
  localparam estado_t EST_STOP  = 2'd3;

endpackage

// File: rtl/uart_tx_bus_if.sv
// CPU memory bus as seen by the UART: store strobe/address/data from the CPU,
// combinational hit flag and read data back. No handshake: one store per strobe cycle.
interface uart_tx_bus_if;
  logic [31:0] dir;
  logic [31:0] dat_escritura;
  logic        hab_escritura;
  logic        acierto;
  logic [31:0] dat_lectura;

  modport master (output dir, dat_escritura, hab_escritura, input acierto, dat_lectura);
  modport slave  (input dir, dat_escritura, hab_escritura, output acierto, dat_lectura);
endinterface

// File: rtl/fifo_sinc.sv
// Synchronous show-ahead FIFO, power-of-two depth, async active-high reset.
// A push while full is accepted only when a pop happens in the same cycle.
module fifo_sinc #(
  parameter int ANCHO = 8,
  parameter int PROF  = 8,
  localparam int AP   = $clog2(PROF)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [ANCHO-1:0] dato_in,
  input  logic             pop,
  output logic [ANCHO-1:0] dato_out,
  output logic             lleno,
  output logic             vacio,
  output logic [AP:0]      count
);

  logic [ANCHO-1:0] mem [PROF];
  logic [AP-1:0]    wr_ptr;
  logic [AP-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign lleno    = (count == (AP+1)'(PROF));
  assign vacio    = (count == '0);
  assign pop_ok   = pop && !vacio;
  assign push_ok  = push && (!lleno || pop_ok);
  assign dato_out = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= dato_in;
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_bus.sv
// Memory-mapped 8N1 UART transmitter (DATA / STATUS / DIVISOR registers).
// Define UART_TX_FIFO_EN for a PROF_FIFO-deep transmit FIFO; otherwise a single holding register.
module uart_tx_bus
  import uart_pkg::*;
#(
  parameter logic [31:0] DIR_BASE  = 32'h0000_1000,
  parameter logic [15:0] DIV_RESET = 16'd868,
  parameter int          PROF_FIFO = 8
) (
  input  logic          clk,
  input  logic          reset,
  uart_tx_bus_if.slave  bus,
  output logic          tx,
  output estado_t       estado_dbg
);

  estado_t     estado;
  logic [15:0] div;
  logic [15:0] lat_div;
  logic [15:0] cnt_bit;
  logic [2:0]  idx;
  logic [7:0]  shreg;
  logic        desborde;
  logic [1:0]  ofs;
  logic        wr_data, wr_status, wr_div;
  logic        bit_fin, pop, push;
  logic        lleno, vacio;
  logic [3:0]  cuenta;
  logic [7:0]  dato_buf;
  logic [7:0]  status;
  logic        unused_bits;

  assign estado_dbg  = estado;
  assign ofs         = bus.dir[3:2];
  assign bus.acierto = (bus.dir[31:4] == DIR_BASE[31:4]);
  assign wr_data     = bus.hab_escritura && bus.acierto && (ofs == OFS_DATA);
  assign wr_status   = bus.hab_escritura && bus.acierto && (ofs == OFS_STATUS);
  assign wr_div      = bus.hab_escritura && bus.acierto && (ofs == OFS_DIV);
  assign unused_bits = ^{bus.dat_escritura[31:16], bus.dir[1:0]};

  assign bit_fin = (cnt_bit == lat_div - 16'd1);
  assign pop     = !vacio && ((estado == EST_IDLE) || ((estado == EST_STOP) && bit_fin));
  assign push    = wr_data && (!lleno || pop);

`ifdef UART_TX_FIFO_EN
  logic [$clog2(PROF_FIFO):0] cnt_fifo;

  fifo_sinc #(.ANCHO(8), .PROF(PROF_FIFO)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .dato_in  (bus.dat_escritura[7:0]),
    .pop      (pop),
    .dato_out (dato_buf),
    .lleno    (lleno),
    .vacio    (vacio),
    .count    (cnt_fifo)
  );
  assign cuenta = 4'(cnt_fifo);
`else
  logic       ocupa;
  logic [7:0] reg_hold;
  logic [7:0] unused_prof;

  assign unused_prof = 8'(PROF_FIFO);

  // Holding register: a push in the same cycle as the pop refills it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ocupa    <= 1'b0;
      reg_hold <= 8'h00;
    end else if (push) begin
      ocupa    <= 1'b1;
      reg_hold <= bus.dat_escritura[7:0];
    end else if (pop) begin
      ocupa    <= 1'b0;
    end
  end
  assign lleno    = ocupa;
  assign vacio    = !ocupa;
  assign cuenta   = {3'b000, ocupa};
  assign dato_buf = reg_hold;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div      <= DIV_RESET;
      desborde <= 1'b0;
    end else begin
      if (wr_div) div <= (bus.dat_escritura[15:0] == 16'd0) ? 16'd1 : bus.dat_escritura[15:0];
      if (wr_data && lleno && !pop) desborde <= 1'b1;
      else if (wr_status && bus.dat_escritura[ST_DESBORDE]) desborde <= 1'b0;
    end
  end

  // Serializer: the divisor is latched at each pop so mid-frame writes only affect the next frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado  <= EST_IDLE;
      tx      <= 1'b1;
      shreg   <= 8'h00;
      lat_div <= DIV_RESET;
      cnt_bit <= 16'd0;
      idx     <= 3'd0;
    end else begin
      case (estado)
        EST_IDLE: begin
          if (!vacio) begin
            estado  <= EST_START;
            tx      <= 1'b0;
            shreg   <= dato_buf;
            lat_div <= div;
            cnt_bit <= 16'd0;
          end
        end
        EST_START: begin
          if (bit_fin) begin
            cnt_bit <= 16'd0;
            estado  <= EST_DATA;
            idx     <= 3'd0;
            tx      <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
          end else begin
            cnt_bit <= cnt_bit + 16'd1;
          end
        end
        EST_DATA: begin
          if (bit_fin) begin
            cnt_bit <= 16'd0;
            if (idx == 3'd7) begin
              estado <= EST_STOP;
              tx     <= 1'b1;
            end else begin
              idx   <= idx + 3'd1;
              tx    <= shreg[0];
              shreg <= {1'b0, shreg[7:1]};
            end
          end else begin
            cnt_bit <= cnt_bit + 16'd1;
          end
        end
        EST_STOP: begin
          if (bit_fin) begin
            cnt_bit <= 16'd0;
            if (!vacio) begin
              estado  <= EST_START;
              tx      <= 1'b0;
              shreg   <= dato_buf;
              lat_div <= div;
            end else begin
              estado <= EST_IDLE;
            end
          end else begin
            cnt_bit <= cnt_bit + 16'd1;
          end
        end
        default: estado <= EST_IDLE;
      endcase
    end
  end

  always_comb begin
    status = 8'h00;
    status[ST_OCUPADO]          = (estado != EST_IDLE);
    status[ST_LLENO]            = lleno;
    status[ST_VACIO]            = vacio;
    status[ST_DESBORDE]         = desborde;
    status[ST_COUNT_LSB +: 4]   = cuenta;
  end

  always_comb begin
    bus.dat_lectura = 32'h0;
    if (bus.acierto) begin
      case (ofs)
        OFS_STATUS: bus.dat_lectura = {24'h0, status};
        OFS_DIV:    bus.dat_lectura = {16'h0, div};
        default:    bus.dat_lectura = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_bus.sv
// Bench for uart_tx_bus: register table, hand-written frame sequences and random
// traffic checked cycle by cycle against a frame-timing reference model.
module tb_uart_tx_bus;
  import uart_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_1000;
`ifdef UART_TX_FIFO_EN
  localparam int CAP = 8;
`else
  localparam int CAP = 1;
`endif

  typedef struct {
    logic        hab;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic        exp_ac;
    logic [31:0] exp_rd;
  } vec_t;

  logic    clk = 1'b0;
  logic    reset;
  logic    tx;
  estado_t estado_dbg;

  uart_tx_bus_if bus ();

  uart_tx_bus #(.DIR_BASE(BASE), .DIV_RESET(16'd868), .PROF_FIFO(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .tx         (tx),
    .estado_dbg (estado_dbg)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         busy_cnt = 0;
  int         cyc = 0;
  logic [7:0] exp_q[$];
  logic       desb_m;
  int         div_m;
  bit         have_frame;
  int         last_p, last_d;
  logic [7:0] last_b;
  vec_t       tbl[15];
  logic [9:0] pat_a5;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // A frame popped at edge p occupies edges p .. p+10*d-1; bit k spans d cycles.
  function automatic bit busy_m();
    return have_frame && (cyc < last_p + 10 * last_d);
  endfunction

  function automatic logic tx_m();
    int k;
    if (!busy_m()) return 1'b1;
    k = (cyc - last_p) / last_d;
    if (k == 0) return 1'b0;
    if (k <= 8) return last_b[k-1];
    return 1'b1;
  endfunction

  function automatic logic [31:0] status_m();
    logic [31:0] s;
    s      = 32'h0;
    s[0]   = busy_m();
    s[1]   = (exp_q.size() == CAP);
    s[2]   = (exp_q.size() == 0);
    s[3]   = desb_m;
    s[7:4] = 4'(exp_q.size());
    return s;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    desb_m     = 1'b0;
    div_m      = 868;
    have_frame = 1'b0;
  endtask

  task automatic model_edge();
    cyc++;
    if (exp_q.size() > 0 && (!have_frame || cyc >= last_p + 10 * last_d)) begin
      last_b     = exp_q.pop_front();
      last_p     = cyc;
      last_d     = div_m;
      have_frame = 1'b1;
    end
    if (bus.hab_escritura && bus.dir[31:4] == BASE[31:4]) begin
      case (bus.dir[3:2])
        OFS_DATA:   if (exp_q.size() < CAP) exp_q.push_back(bus.dat_escritura[7:0]);
                    else desb_m = 1'b1;
        OFS_STATUS: if (bus.dat_escritura[3]) desb_m = 1'b0;
        OFS_DIV:    div_m = (bus.dat_escritura[15:0] == 16'd0) ? 1 : int'(bus.dat_escritura[15:0]);
        default: ;
      endcase
    end
  endtask

  task automatic drive(input logic h, input logic [31:0] a, input logic [31:0] d);
    bus.hab_escritura = h;
    bus.dir           = a;
    bus.dat_escritura = d;
  endtask

  task automatic clk_edge();
    @(posedge clk);
    model_edge();
    #1;
    drive(1'b0, BASE + 32'h4, 32'h0);
    #1;
    check("tx", {31'b0, tx}, {31'b0, tx_m()});
    check("status", bus.dat_lectura, status_m());
    if (bus.dat_lectura[0]) busy_cnt++;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, a, d);
    clk_edge();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, BASE + 32'h4, 32'h0);
      clk_edge();
    end
  endtask

  initial begin
    tbl[0]  = '{1'b0, BASE + 32'h4,  32'h0,         1'b1, 32'h4};
    tbl[1]  = '{1'b0, BASE + 32'h8,  32'h0,         1'b1, 32'h364};
    tbl[2]  = '{1'b0, BASE,          32'h0,         1'b1, 32'h0};
    tbl[3]  = '{1'b0, BASE + 32'hC,  32'h0,         1'b1, 32'h0};
    tbl[4]  = '{1'b1, BASE + 32'hC,  32'hFFFF_FFFF, 1'b1, 32'h0};
    tbl[5]  = '{1'b0, BASE + 32'hC,  32'h0,         1'b1, 32'h0};
    tbl[6]  = '{1'b1, BASE + 32'h10, 32'hAB,        1'b0, 32'h0};
    tbl[7]  = '{1'b1, BASE - 32'h4,  32'h5,         1'b0, 32'h0};
    tbl[8]  = '{1'b0, BASE + 32'h4,  32'h0,         1'b1, 32'h4};
    tbl[9]  = '{1'b1, BASE + 32'h8,  32'h0,         1'b1, 32'h364};
    tbl[10] = '{1'b0, BASE + 32'h8,  32'h0,         1'b1, 32'h1};
    tbl[11] = '{1'b1, BASE + 32'hB,  32'hABCD_1234, 1'b1, 32'h1};
    tbl[12] = '{1'b0, BASE + 32'h9,  32'h0,         1'b1, 32'h1234};
    tbl[13] = '{1'b1, BASE + 32'h8,  32'h4,         1'b1, 32'h1234};
    tbl[14] = '{1'b0, BASE + 32'h8,  32'h0,         1'b1, 32'h4};
    pat_a5  = 10'b11_0100_1010;

    // Clock/reset
    reset = 1'b1;
    drive(1'b0, BASE + 32'h4, 32'h0);
    model_reset();
    #1;
    check("reset_tx", {31'b0, tx}, 32'h1);
    check("reset_state", {30'b0, estado_dbg}, {30'b0, EST_IDLE});
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    // Register table
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].hab, tbl[i].addr, tbl[i].wdat);
      #1;
      check($sformatf("tbl%0d_acierto", i), {31'b0, bus.acierto}, {31'b0, tbl[i].exp_ac});
      check($sformatf("tbl%0d_rd", i), bus.dat_lectura, tbl[i].exp_rd);
      clk_edge();
    end

    // Single 0xA5 frame at divisor 4
    wr(BASE, 32'hA5);
    busy_cnt = 0;
    for (int j = 0; j < 40; j++) begin
      idle(1);
      check("a5_bit", {31'b0, tx}, {31'b0, pat_a5[j/4]});
    end
    idle(5);
    check("a5_busy_cycles", busy_cnt, 40);

    // Burst at divisor 2: fill, overflow, clear
    wr(BASE + 32'h8, 32'h2);
    for (int i = 0; i < 9; i++) wr(BASE, $urandom_range(0, 255));
    check("burst9_desborde", {31'b0, bus.dat_lectura[3]}, (CAP >= 8) ? 32'h0 : 32'h1);
    for (int i = 0; i < 10; i++) wr(BASE, $urandom_range(0, 255));
    check("burst_desborde", {31'b0, bus.dat_lectura[3]}, 32'h1);
    check("burst_count", {28'b0, bus.dat_lectura[7:4]}, CAP);
    wr(BASE + 32'h4, 32'h8);
    check("clear_desborde", {31'b0, bus.dat_lectura[3]}, 32'h0);
    idle(250);

    // Divisor 0 is stored as 1
    wr(BASE + 32'h8, 32'h0);
    bus.dir = BASE + 32'h8;
    #1;
    check("div0_readback", bus.dat_lectura, 32'h1);
    busy_cnt = 0;
    wr(BASE, 32'hFF);
    idle(20);
    check("div1_frame_len", busy_cnt, 10);

    // Divisor change mid-frame only affects the following frame
    wr(BASE + 32'h8, 32'h3);
    busy_cnt = 0;
    wr(BASE, 32'h3C);
    wr(BASE, 32'hC3);
    idle(5);
    wr(BASE + 32'h8, 32'h8);
    idle(120);
    check("middiv_busy_cycles", busy_cnt, 110);

    // Asynchronous reset mid-frame
    wr(BASE + 32'h8, 32'h4);
    wr(BASE, 32'h55);
    idle(10);
    reset = 1'b1;
    #1;
    check("async_rst_tx", {31'b0, tx}, 32'h1);
    check("async_rst_status", bus.dat_lectura, 32'h4);
    bus.dir = BASE + 32'h8;
    #1;
    check("async_rst_div", bus.dat_lectura, 32'h364);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    model_reset();
    idle(3);

    // Random traffic
    wr(BASE + 32'h8, 32'h1);
    for (int i = 0; i < 2000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 25)      wr(BASE, $urandom_range(0, 255));
      else if (r < 29) wr(BASE + 32'h8, $urandom_range(0, 4));
      else if (r < 32) wr(BASE + 32'h4, $urandom_range(0, 15));
      else if (r < 35) wr(BASE + 32'h10 + 32'($urandom_range(0, 15)), $urandom_range(0, 255));
      else if (r < 37) wr(BASE + 32'hC, $urandom);
      else             idle(1);
    end
    idle(500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
